// File: rtl/pkt_defs_pkg.sv
// Shared packet definitions for the 134b flit format.
// Flit layout: [133:132] tag, [131:128] last valid byte index, [127:0] payload.
// Tag bit 132 marks a packet's first flit, tag bit 133 marks its last flit.
package pkt_defs_pkg;

    localparam int DATA_W     = 134;
    localparam int LEN_W      = 16;

    localparam int TAG_HI     = 133;
    localparam int TAG_LO     = 132;
    localparam int LBI_HI     = 131;
    localparam int LBI_LO     = 128;
    localparam int PAYLOAD_HI = 127;

    localparam int TAIL_BIT   = 133;
    localparam int HEAD_BIT   = 132;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;
    localparam logic [1:0] TAG_BODY = 2'b00;

    typedef enum logic {
        ST_ARB,
        ST_XFER
    } arb_state_e;

    function automatic logic [DATA_W-1:0] make_flit(input logic [1:0]   tag,
                                                    input logic [3:0]   lbi,
                                                    input logic [127:0] payload);
        logic [DATA_W-1:0] f;
        f                   = '0;
        f[TAG_HI:TAG_LO]    = tag;
        f[LBI_HI:LBI_LO]    = lbi;
        f[PAYLOAD_HI:0]     = payload;
        return f;
    endfunction

endpackage

// File: rtl/pkt_rr_arbiter_134b_if.sv
// Bundle of the arbiter's packet-stream handshake signals.
//   in_valid/in_data/in_length/in_ready : N_PORTS source streams
//   out_valid/out_data/out_length/out_port/out_ready : merged stream
// master: the environment (sources and downstream consumer)
// slave : the arbiter
interface pkt_rr_arbiter_134b_if #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned DATA_W  = 134,
    parameter int unsigned LEN_W   = 16
);
    localparam int unsigned PORT_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0]        in_valid;
    logic [N_PORTS*DATA_W-1:0] in_data;
    logic [N_PORTS*LEN_W-1:0]  in_length;
    logic [N_PORTS-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [LEN_W-1:0]          out_length;
    logic [PORT_W-1:0]         out_port;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, in_length, out_ready,
        input  in_ready, out_valid, out_data, out_length, out_port
    );

    modport slave (
        input  in_valid, in_data, in_length, out_ready,
        output in_ready, out_valid, out_data, out_length, out_port
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   req        : request vector
//   last_grant : index granted last time; scanning starts one above it
//   grant      : first requester found scanning upward with wrap-around
//   any        : at least one request is set
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any
);
    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = W'((32'(last_grant) + i) % N);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter_134b.sv
// Packet-granular round-robin arbiter: merges N_PORTS 134b packet streams
// into one, holding a grant from a packet's first flit to its tail flit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream handshakes (slave side of pkt_rr_arbiter_134b_if)
//   cnt_pkt    : per-port forwarded packet count, 32b per port
//   cnt_err    : per-port count of first flits lacking the head bit, 16b per port
module pkt_rr_arbiter_134b #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned DATA_W  = 134,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pkt_rr_arbiter_134b_if.slave   bus,
    output logic [N_PORTS*32-1:0]  cnt_pkt,
    output logic [N_PORTS*16-1:0]  cnt_err
);
    import pkt_defs_pkg::*;

    localparam int unsigned PORT_W = $clog2(N_PORTS);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;
    logic              first_flit_q, first_flit_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [LEN_W-1:0]  out_length_q, out_length_d;
    logic [PORT_W-1:0] out_port_q, out_port_d;
    logic [31:0]       cnt_pkt_q [N_PORTS];
    logic [31:0]       cnt_pkt_d [N_PORTS];
    logic [15:0]       cnt_err_q [N_PORTS];
    logic [15:0]       cnt_err_d [N_PORTS];

    logic [DATA_W-1:0]  flit_arr [N_PORTS];
    logic [LEN_W-1:0]   len_arr  [N_PORTS];
    logic [DATA_W-1:0]  cur_flit;
    logic [LEN_W-1:0]   cur_len;
    logic [PORT_W-1:0]  pick_grant;
    logic               pick_any;
    logic               slot_free;
    logic               in_xfer;
    logic [N_PORTS-1:0] in_ready;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign flit_arr[g]          = bus.in_data[g*DATA_W +: DATA_W];
        assign len_arr[g]           = bus.in_length[g*LEN_W +: LEN_W];
        assign cnt_pkt[g*32 +: 32]  = cnt_pkt_q[g];
        assign cnt_err[g*16 +: 16]  = cnt_err_q[g];
    end

    rr_pick #(.N(N_PORTS), .W(PORT_W)) u_rr_pick (
        .req        (bus.in_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    assign cur_flit  = flit_arr[grant_q];
    assign cur_len   = len_arr[grant_q];
    // The output slice can take a flit when empty or draining this cycle.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_xfer   = (state_q == ST_XFER) && bus.in_valid[grant_q] && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(N_PORTS - 1);
            first_flit_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_length_q <= '0;
            out_port_q   <= '0;
            cnt_pkt_q    <= '{default: '0};
            cnt_err_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_flit_q <= first_flit_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_length_q <= out_length_d;
            out_port_q   <= out_port_d;
            cnt_pkt_q    <= cnt_pkt_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_flit_d = first_flit_q;
        unique case (state_q)
            ST_ARB: begin
                if (pick_any) begin
                    grant_d      = pick_grant;
                    first_flit_d = 1'b1;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                if (in_xfer) begin
                    first_flit_d = 1'b0;
                    if (cur_flit[TAIL_BIT]) begin
                        last_grant_d = grant_q;
                        state_d      = ST_ARB;
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (state_q == ST_XFER) begin
            in_ready[grant_q] = slot_free;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_length_d = out_length_q;
        out_port_d   = out_port_q;
        cnt_pkt_d    = cnt_pkt_q;
        cnt_err_d    = cnt_err_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = cur_flit;
            if (first_flit_q) begin
                out_length_d = cur_len;
                out_port_d   = grant_q;
                // Malformed first flit is counted but still forwarded.
                if (!cur_flit[HEAD_BIT]) begin
                    cnt_err_d[grant_q] = cnt_err_q[grant_q] + 16'd1;
                end
            end
            if (cur_flit[TAIL_BIT]) begin
                cnt_pkt_d[grant_q] = cnt_pkt_q[grant_q] + 32'd1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_length = out_length_q;
    assign bus.out_port   = out_port_q;

endmodule

// File: tb/tb_pkt_rr_arbiter_134b.sv
// Self-checking bench for pkt_rr_arbiter_134b: per-port packet sources, a
// round-robin ordering model over whole packets and a flit scoreboard.
module tb_pkt_rr_arbiter_134b;
    import pkt_defs_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 134;
    localparam int unsigned LW = 16;
    localparam int unsigned PW = 2;

    typedef struct packed {
        logic [DW-1:0] flit;
        logic [LW-1:0] len;
        logic [PW-1:0] port;
        logic          first;
        logic          last;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_rr_arbiter_134b_if #(.N_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) bus ();
    logic [NP*32-1:0] cnt_pkt;
    logic [NP*16-1:0] cnt_err;

    pkt_rr_arbiter_134b #(.N_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_pkt (cnt_pkt),
        .cnt_err (cnt_err)
    );

    item_t       src_q [NP][$];
    item_t       mdl_q [NP][$];
    item_t       exp_q [$];
    int unsigned exp_pkt [NP];
    int unsigned exp_err [NP];
    logic [PW-1:0] mdl_last;
    int unsigned n_pass, n_total, cyc, phase_start, prev_out_cyc;
    bit          strict, gaps, bp, first_out;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_pkt(input int unsigned p, input int unsigned nfl,
                            input logic [LW-1:0] len, input bit bad);
        item_t it;
        logic [1:0] tag;
        for (int unsigned i = 0; i < nfl; i++) begin
            tag = TAG_BODY;
            if (i == 0 && !bad) tag = tag | TAG_HEAD;
            if (i == nfl - 1)   tag = tag | TAG_TAIL;
            it.flit  = make_flit(tag, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
            it.len   = len;
            it.port  = PW'(p);
            it.first = (i == 0);
            it.last  = (i == nfl - 1);
            src_q[p].push_back(it);
            mdl_q[p].push_back(it);
        end
        exp_pkt[p]++;
        if (bad) exp_err[p]++;
    endtask

    // Whole packets are served in round-robin order over ports that still
    // have packets waiting, starting after the previously served port.
    task automatic plan();
        bit more;
        bit found;
        int unsigned p, sel;
        item_t it;
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            sel   = 0;
            for (int unsigned i = 1; i <= NP; i++) begin
                p = (32'(mdl_last) + i) % NP;
                if (!found && mdl_q[p].size() != 0) begin
                    found = 1'b1;
                    sel   = p;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                do begin
                    it = mdl_q[sel].pop_front();
                    exp_q.push_back(it);
                end while (!it.last);
                mdl_last = PW'(sel);
            end
        end
    endtask

    task automatic cycle();
        logic [NP-1:0]    v;
        logic [NP*DW-1:0] d;
        logic [NP*LW-1:0] l;
        item_t it;
        @(negedge clk);
        v = '0;
        d = '0;
        l = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) begin
                it = src_q[p][0];
                v[p] = it.first || !gaps || ($urandom_range(0, 3) != 0);
                d[p*DW +: DW] = it.flit;
                l[p*LW +: LW] = it.len;
            end
        end
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_length = l;
        bus.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        check("in_ready_onehot", DW'($onehot0(bus.in_ready)), DW'(1));
        if (bus.out_valid && !bus.out_ready)
            check("in_ready_stall", DW'(bus.in_ready), '0);
        if (bus.out_valid && bus.out_ready) begin
            check("exp_avail", DW'(exp_q.size() != 0), DW'(1));
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check("out_data",   bus.out_data,           it.flit);
                check("out_length", DW'(bus.out_length),    DW'(it.len));
                check("out_port",   DW'(bus.out_port),      DW'(it.port));
                if (strict) begin
                    if (first_out)     check("latency",  DW'(cyc - phase_start),  DW'(2));
                    else if (it.first) check("arb_gap",  DW'(cyc - prev_out_cyc), DW'(2));
                    else               check("stream",   DW'(cyc - prev_out_cyc), DW'(1));
                end
                prev_out_cyc = cyc;
                first_out    = 1'b0;
            end
        end
        for (int unsigned p = 0; p < NP; p++) begin
            if (v[p] && bus.in_ready[p]) void'(src_q[p].pop_front());
        end
        cyc++;
    endtask

    task automatic check_counters();
        for (int unsigned p = 0; p < NP; p++) begin
            check($sformatf("cnt_pkt[%0d]", p), DW'(cnt_pkt[p*32 +: 32]), DW'(exp_pkt[p]));
            check($sformatf("cnt_err[%0d]", p), DW'(cnt_err[p*16 +: 16]), DW'(exp_err[p]));
        end
    endtask

    task automatic run_phase(input bit s, input bit g, input bit b, input int unsigned max_cyc);
        int unsigned n;
        strict = s;
        gaps   = g;
        bp     = b;
        plan();
        phase_start = cyc;
        first_out   = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        check("phase_done", DW'(exp_q.size()), '0);
        check_counters();
    endtask

    task automatic clear_model();
        for (int unsigned p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            exp_pkt[p] = 0;
            exp_err[p] = 0;
        end
        exp_q.delete();
        mdl_last = PW'(NP - 1);
    endtask

    task automatic check_reset_values();
        check("rst_out_valid",  DW'(bus.out_valid),  '0);
        check("rst_out_data",   bus.out_data,        '0);
        check("rst_out_length", DW'(bus.out_length), '0);
        check("rst_out_port",   DW'(bus.out_port),   '0);
        check("rst_in_ready",   DW'(bus.in_ready),   '0);
        check("rst_cnt_pkt",    DW'(cnt_pkt),        '0);
        check("rst_cnt_err",    DW'(cnt_err),        '0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        prev_out_cyc = 0;
        strict = 1'b0;
        gaps = 1'b0;
        bp = 1'b0;
        first_out = 1'b1;
        clear_model();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_length = '0;
        bus.out_ready = 1'b1;

        // Reset state, with a source already requesting: ARB must not accept.
        bus.in_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        bus.in_valid = '0;
        rst_n = 1'b1;

        // Single 3-flit packet on port 0, length 48.
        load_pkt(0, 3, 16'd48, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 50);

        // All ports holding two 2-flit packets each.
        for (int unsigned r = 0; r < 2; r++)
            for (int unsigned p = 0; p < NP; p++)
                load_pkt(p, 2, LW'($urandom), 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 200);

        // Bad first flit (tag 00) then tail on port 3; single tag-11 flit on port 1.
        load_pkt(3, 2, 16'd100, 1'b1);
        load_pkt(1, 1, 16'd7, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 50);

        // 4-flit packet under random backpressure.
        load_pkt(2, 4, 16'd200, 1'b0);
        run_phase(1'b0, 1'b0, 1'b1, 200);

        // Randomized traffic with source gaps and backpressure.
        for (int unsigned k = 0; k < 40; k++)
            load_pkt($urandom_range(0, NP - 1), $urandom_range(1, 5), LW'($urandom),
                     $urandom_range(0, 9) == 0);
        run_phase(1'b0, 1'b1, 1'b1, 3000);

        // Reset mid-packet on port 2, then first grant after reset goes to port 0.
        load_pkt(2, 4, 16'd64, 1'b0);
        strict = 1'b0;
        gaps = 1'b0;
        bp = 1'b0;
        plan();
        repeat (4) cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        clear_model();
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        load_pkt(1, 2, 16'd11, 1'b0);
        load_pkt(0, 2, 16'd22, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
